// File: rtl/iterative_alu.sv
// ----------------------------------------------------------------------------
// iterative_alu
//   Execute-stage ALU. ADD/SUB/logic/compare results are produced in one
//   cycle. Shifts are produced one bit per cycle, unless ALU_FAST_SHIFT_EN is
//   defined, in which case a barrel shifter gives single-cycle shifts and the
//   SHIFT state and counter are not built.
//
//   Configuration macro: ALU_FAST_SHIFT_EN (undefined = iterative shifter)
//
//   Ports
//     i_clk          clock, rising edge
//     i_rst          synchronous active-high reset
//     i_flush        abort any in-flight operation, return to IDLE
//     i_valid        request valid
//     o_ready        unit can accept a request (registered)
//     i_alu_control  5-bit operation code
//     i_op_a         operand A
//     i_op_b         operand B (shift amount in low $clog2(XLEN) bits)
//     o_valid        result valid (registered)
//     i_ready        consumer accepts result
//     o_result       result (registered, stable while o_valid)
//     o_zero         o_result == 0 (registered)
// ----------------------------------------------------------------------------
module iterative_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00110;
    localparam logic [4:0] OP_SUB  = 5'b10000;
    localparam logic [4:0] OP_SLTU = 5'b11000;
    localparam logic [4:0] OP_SLT  = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifndef ALU_FAST_SHIFT_EN
        ST_SHIFT = 2'd1,
`endif
        ST_DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [SHAMT_W-1:0]   shamt_c;
    logic                 is_shift_c;
    logic [XLEN-1:0]      alu_res_c;
    logic [XLEN-1:0]      idle_res_c;
    logic                 accept_c;

    assign shamt_c  = i_op_b[SHAMT_W-1:0];
    assign accept_c = i_valid && o_ready;

    // Single-cycle datapath; unknown codes fall through to ADD
    always_comb begin
        alu_res_c  = i_op_a + i_op_b;
        is_shift_c = 1'b0;
        case (i_alu_control)
            OP_ADD:  alu_res_c = i_op_a + i_op_b;
            OP_SUB:  alu_res_c = i_op_a - i_op_b;
            OP_AND:  alu_res_c = i_op_a & i_op_b;
            OP_OR:   alu_res_c = i_op_a | i_op_b;
            OP_XOR:  alu_res_c = i_op_a ^ i_op_b;
            OP_SLT:  alu_res_c = XLEN'($signed(i_op_a) < $signed(i_op_b));
            OP_SLTU: alu_res_c = XLEN'(i_op_a < i_op_b);
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res_c = i_op_a << shamt_c;
            OP_SRL:  alu_res_c = i_op_a >> shamt_c;
            OP_SRA:  alu_res_c = XLEN'($signed(i_op_a) >>> shamt_c);
`else
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res_c  = i_op_a;
                is_shift_c = 1'b1;
            end
`endif
            default: alu_res_c = i_op_a + i_op_b;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN

    assign idle_res_c = alu_res_c;

    // Every accepted op completes on the accept edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_result <= '0;
            o_zero   <= 1'b0;
        end else if (i_flush) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        o_result <= idle_res_c;
                        o_zero   <= (idle_res_c == '0);
                        o_valid  <= 1'b1;
                        o_ready  <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`else

    // Shift direction: 00 SLL, 01 SRL, 10 SRA (low bits of the opcode)
    function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                 input logic [1:0]      kind);
        case (kind)
            2'b01:   shift_one = {1'b0, v[XLEN-1:1]};
            2'b10:   shift_one = {v[XLEN-1], v[XLEN-1:1]};
            default: shift_one = {v[XLEN-2:0], 1'b0};
        endcase
    endfunction

    logic [XLEN-1:0]    work;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         shift_kind;
    logic [XLEN-1:0]    first_c;
    logic [XLEN-1:0]    step_c;
    logic               start_shift_c;

    // The accept edge performs the first shift step, so an N-bit shift
    // reports valid N cycles after accept (1-bit shift matches ALU latency).
    assign first_c       = shift_one(i_op_a, i_alu_control[1:0]);
    assign step_c        = shift_one(work, shift_kind);
    assign start_shift_c = is_shift_c && (shamt_c > SHAMT_W'(1));

    always_comb begin
        idle_res_c = alu_res_c;
        if (is_shift_c && (shamt_c != '0)) begin
            idle_res_c = first_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
            o_result   <= '0;
            o_zero     <= 1'b0;
            work       <= '0;
            count      <= '0;
            shift_kind <= 2'b00;
        end else if (i_flush) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        o_ready <= 1'b0;
                        if (start_shift_c) begin
                            work       <= first_c;
                            count      <= shamt_c - SHAMT_W'(1);
                            shift_kind <= i_alu_control[1:0];
                            state      <= ST_SHIFT;
                        end else begin
                            o_result <= idle_res_c;
                            o_zero   <= (idle_res_c == '0);
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        o_result <= step_c;
                        o_zero   <= (step_c == '0);
                        o_valid  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        work <= step_c;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_iterative_alu.sv
// ----------------------------------------------------------------------------
// tb_iterative_alu
//   Directed bench for iterative_alu. Stimulus pushes expected results into a
//   queue; a monitor pops and compares on every result handshake. Latency,
//   back-pressure, flush and reset behaviour are checked by the stimulus.
// ----------------------------------------------------------------------------
module tb_iterative_alu;

    localparam int unsigned XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_flush = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [4:0]      i_alu_control = 5'b0;
    logic [XLEN-1:0] i_op_a = '0;
    logic [XLEN-1:0] i_op_b = '0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [XLEN-1:0] o_result;
    logic            o_zero;

    int errors = 0;
    int checks = 0;
    logic [XLEN:0] exp_q[$];

    iterative_alu #(.XLEN(XLEN)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_alu_control (i_alu_control),
        .i_op_a        (i_op_a),
        .i_op_b        (i_op_b),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_zero        (o_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: one comparison per result handshake
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h, expected no result", o_result);
            end else begin
                logic [XLEN:0] e;
                e = exp_q.pop_front();
                check("result", o_result, e[XLEN-1:0]);
                check("zero", 32'(o_zero), 32'(e[XLEN]));
            end
        end
    end

    task automatic drive_edge();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op, measure cycles until o_valid, then let it pop
    task automatic do_op(input string name, input logic [4:0] code,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int k;
        @(negedge i_clk);
        check({name, "_ready_in"}, 32'(o_ready), 32'd1);
        drive_edge();
        i_alu_control = code;
        i_op_a  = a;
        i_op_b  = b;
        i_valid = 1'b1;
        exp_q.push_back({(exp == 32'd0), exp});
        k = 0;
        do begin
            drive_edge();
            k++;
            if (k == 1) begin
                i_valid       = 1'b0;
                i_alu_control = 5'b00000;
                i_op_a        = ~a;
                i_op_b        = ~b;
            end
            @(negedge i_clk);
        end while (!o_valid && k < 64);
        check({name, "_latency"}, 32'(k), 32'(lat));
        drive_edge();
        @(negedge i_clk);
        check({name, "_ready_after_pop"}, {30'd0, o_valid, o_ready}, 32'd1);
    endtask

    function automatic int sh_lat(input int amt);
        return (FAST || amt == 0) ? 1 : amt;
    endfunction

    initial begin
        bit seen;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_valid",  32'(o_valid),  32'd0);
        check("reset_ready",  32'(o_ready),  32'd1);
        check("reset_result", o_result,      32'd0);
        check("reset_zero",   32'(o_zero),   32'd0);

        do_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        do_op("sub_zero", 5'b10000, 32'd5, 32'd5, 32'd0, 1);
        do_op("sub_wrap", 5'b10000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
        do_op("slt", 5'b10111, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1);
        do_op("sltu", 5'b11000, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1);
        do_op("undef", 5'b01111, 32'd3, 32'd4, 32'd7, 1);
        do_op("and", 5'b00001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        do_op("or", 5'b00010, 32'h0000_FFFF, 32'h00FF_0000, 32'h00FF_FFFF, 1);
        do_op("sra3", 5'b00110, 32'h8000_0000, 32'h0000_0023, 32'hF000_0000, sh_lat(3));
        do_op("sll0", 5'b00100, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, sh_lat(0));
        do_op("sll1", 5'b00100, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, sh_lat(1));
        do_op("sra4", 5'b00110, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, sh_lat(4));
        do_op("srl31", 5'b00101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, sh_lat(31));

        // Back-pressure: result held, new request refused
        i_ready = 1'b0;
        drive_edge();
        i_alu_control = 5'b00000;
        i_op_a  = 32'h10;
        i_op_b  = 32'h20;
        i_valid = 1'b1;
        exp_q.push_back({1'b0, 32'h30});
        drive_edge();
        i_alu_control = 5'b00011;
        i_op_a = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_hold", {o_ready, o_valid, o_result[29:0]}, {1'b0, 1'b1, 30'h30});
            drive_edge();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drive_edge();
        @(negedge i_clk);
        check("bp_release", {30'd0, o_valid, o_ready}, 32'd1);

        // Flush during SLL by 31, concurrent request ignored
        drive_edge();
        i_alu_control = 5'b00100;
        i_op_a  = 32'h0000_0001;
        i_op_b  = 32'd31;
        i_valid = 1'b1;
        drive_edge();
        i_valid = 1'b0;
        repeat (9) drive_edge();
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_alu_control = 5'b00000;
        i_op_a = 32'd1;
        i_op_b = 32'd1;
        drive_edge();
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("flush_idle", {30'd0, o_valid, o_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Reset in the middle of a shift
        drive_edge();
        i_alu_control = 5'b00101;
        i_op_a  = 32'hF000_0000;
        i_op_b  = 32'd8;
        i_valid = 1'b1;
        drive_edge();
        i_valid = 1'b0;
        repeat (2) drive_edge();
        i_rst = 1'b1;
        drive_edge();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_mid", {o_valid, o_zero, o_ready, 29'd0}, {1'b0, 1'b0, 1'b1, 29'd0});
        check("rst_mid_result", o_result, 32'd0);

        do_op("xor", 5'b00011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1);

        repeat (3) @(negedge i_clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
